conv_result_collector: RTL and testbench
========================================

// Module: conv_result_collector
// PURPOSE
//  Downstream stage of the convolution accelerator. Captures each finished result (finalsum qualified by cReady)
//  and tags it with its (row, col) position in the output image. Buffers results in a small synchronous FIFO and
//  streams them to the PS-side DMA over a valid/ready interface, with end-of-row and end-of-frame markers.
// PARAMETERS
//  DATA_W      16   width of finalsum / m_data
//  IMG_W       8    output pixels per row (>=2)
//  IMG_H       8    output rows per frame (>=1)
//  FIFO_AW     4    FIFO address bits; depth = 2**FIFO_AW entries
// PORTS
//  Clk          in   1          single clock; all logic on posedge
//  RstIn        in   1          asynchronous, active-low reset
//  frame_start  in   1          sync pulse: zero row/col counters, flush FIFO, clear frame_done
//  finalsum     in   DATA_W     accelerator result, valid while cReady high
//  cReady       in   1          accelerator result-ready level; rising edge = one new result
//  clear_err    in   1          sync pulse: clear overflow flag
//  m_data       out  DATA_W     FIFO head data (fall-through)
//  m_valid      out  1          FIFO non-empty
//  m_ready      in   1          consumer accepts head when m_valid & m_ready at posedge
//  m_last       out  1          head is last pixel of its row (col == IMG_W-1)
//  m_frame_end  out  1          head is last pixel of the frame (row == IMG_H-1 and col == IMG_W-1)
//  level        out  FIFO_AW+1  current FIFO occupancy
//  overflow     out  1          sticky: result arrived while FIFO full and no pop in same cycle
//  frame_done   out  1          one-cycle pulse on the pop of the m_frame_end word
// BEHAVIOUR
//  - Reset (RstIn=0, async): every output 0. Counters, pointers and cReady_q cleared; FIFO empty.
//  - Capture: cap = cReady & ~cReady_q (cReady_q is cReady registered). Level-high cReady captures once only.
//  - On cap at edge k: {finalsum, last, frame_end} is written at edge k. m_valid is high after edge k when the
//    FIFO was empty, i.e. latency 1 cycle from the cycle cReady is first seen high.
//  - Position counters col/row advance on every cap, including dropped captures, so tags stay aligned.
//    col wraps IMG_W-1 -> 0 and row increments; at row IMG_H-1, col IMG_W-1 both wrap to 0.
//  - Pop: m_valid & m_ready at edge -> rd_ptr++. m_data/m_last/m_frame_end are the head entry.
//    These outputs are 0 when the FIFO is empty.
//  - Full: cap with level==2**FIFO_AW and no pop -> word dropped, overflow<=1, pointers unchanged.
//    cap with full and a pop in the same cycle -> accepted; level unchanged.
//  - Simultaneous cap + pop when not full/empty: level unchanged. cap + pop when empty: no bypass;
//    the word is written and the pop is ignored, since m_valid was 0.
//  - frame_start has priority over cap and pop in the same cycle: counters=0, pointers=0, level=0.
//    overflow is kept, and the coincident cap is discarded. A result in flight mid-frame is therefore lost by design.
//  - clear_err clears overflow. A same-cycle new overflow event wins (overflow stays 1).
//  - frame_done: registered; high for the one cycle after the edge that popped an entry with frame_end=1.
//  - Pointers are FIFO_AW+1 bits, with wrap via the MSB. level = wr_ptr - rd_ptr (modulo 2**(FIFO_AW+1)).
//  - Data path: finalsum is stored as-is (two's complement), unless CONV_RELU_EN is defined.
// CONFIGURATION
//  CONV_RELU_EN defined: at capture, finalsum[DATA_W-1]==1 (negative) is stored as 0, other values unchanged.
//  CONV_RELU_EN undefined: no clamping; stored word equals finalsum bit-for-bit. Tags and timing are identical in both builds.
// TESTING
//  1 Reset: RstIn=0 mid-stream with level=5 -> all outputs 0 immediately (async); after release level=0, m_valid=0.
//  2 Stream IMG_W=8, IMG_H=8, 64 cReady pulses of finalsum=i, m_ready=1 -> m_data 0..63 in order.
//    m_last on 7,15,..,63; m_frame_end and frame_done only for 63; overflow=0.
//  3 Hold cReady high 10 cycles with finalsum=0x0042 -> exactly one word captured (level=1).
//  4 m_ready=0, 17 pulses with depth 16 -> level=16, overflow=1, word 17 dropped, col counter=1.
//    clear_err -> overflow=0. Drain gives data 0..15 in order.
//  5 Full FIFO, cap and pop in the same cycle -> level stays 16, no overflow. frame_start with cap -> level=0, col=0.
//  6 finalsum=0xFFF0 (-16): with CONV_RELU_EN -> m_data=0x0000; without it -> m_data=0xFFF0.

Source files
------------

// File: rtl/conv_result_collector.sv
// -----------------------------------------------------------------------------
// conv_result_collector
//
// Purpose:
//   Last stage of the convolution accelerator. Each new result (a rising edge
//   of cReady) is captured and tagged with its (row, col) position in the
//   output image. Tagged results go into a small fall-through FIFO. The FIFO
//   is drained by the PS-side DMA over a valid/ready stream, which carries
//   end-of-row and end-of-frame markers.
//
// Parameters:
//   DATA_W   width of finalsum / m_data
//   IMG_W    output pixels per row (>= 2)
//   IMG_H    output rows per frame (>= 1)
//   FIFO_AW  FIFO address bits; depth = 2**FIFO_AW
//
// Build option:
//   CONV_RELU_EN - when defined, negative results are stored as zero.
//                  Tags and timing are the same in both builds.
//
// Ports:
//   Clk          in   clock, all logic on posedge
//   RstIn        in   asynchronous active-low reset
//   frame_start  in   pulse: zero counters, flush FIFO, clear frame_done
//   finalsum     in   accelerator result, valid while cReady is high
//   cReady       in   result-ready level; each rising edge is one result
//   clear_err    in   pulse: clear the sticky overflow flag
//   m_data       out  FIFO head data (0 when empty)
//   m_valid      out  FIFO not empty
//   m_ready      in   consumer takes the head on m_valid & m_ready
//   m_last       out  head is the last pixel of its row
//   m_frame_end  out  head is the last pixel of the frame
//   level        out  FIFO occupancy
//   overflow     out  sticky: a result was dropped because the FIFO was full
//   frame_done   out  one-cycle pulse after the frame_end word is popped
// -----------------------------------------------------------------------------
module conv_result_collector #(
   parameter int DATA_W  = 16,
   parameter int IMG_W   = 8,
   parameter int IMG_H   = 8,
   parameter int FIFO_AW = 4
) (
   input  logic                Clk,
   input  logic                RstIn,
   input  logic                frame_start,
   input  logic [DATA_W-1:0]   finalsum,
   input  logic                cReady,
   input  logic                clear_err,
   output logic [DATA_W-1:0]   m_data,
   output logic                m_valid,
   input  logic                m_ready,
   output logic                m_last,
   output logic                m_frame_end,
   output logic [FIFO_AW:0]    level,
   output logic                overflow,
   output logic                frame_done
);

   localparam int DEPTH = 1 << FIFO_AW;
   // Counter widths. These are kept at a minimum of 1 bit so that an IMG_H of 1
   // still produces a legal vector.
   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   localparam logic [CW-1:0]    COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0]    ROW_LAST = RW'(IMG_H - 1);
   localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(DEPTH);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
      logic              fend;
   } entry_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   entry_t             r_mem [DEPTH];
   logic [FIFO_AW:0]   r_wr_ptr;
   logic [FIFO_AW:0]   r_rd_ptr;
   logic               r_cready_q;
   logic [CW-1:0]      r_col;
   logic [RW-1:0]      r_row;
   logic               r_overflow;
   logic               r_frame_done;

   // ---------------------------------------------------------------------------
   // Combinational control
   // ---------------------------------------------------------------------------
   logic [FIFO_AW:0]   w_level;
   logic               w_empty;
   logic               w_full;
   logic               w_cap;
   logic               w_pop;
   logic               w_wr;
   logic               w_drop;
   logic               w_col_last;
   logic               w_row_last;
   logic [DATA_W-1:0]  w_store;
   entry_t             w_head;
   entry_t             w_wr_entry;

   // The pointers carry one extra bit, so a full FIFO and an empty FIFO give
   // different differences. Subtraction wraps modulo 2**(FIFO_AW+1).
   assign w_level    = r_wr_ptr - r_rd_ptr;
   assign w_empty    = (w_level == '0);
   assign w_full     = (w_level == FULL_LVL);

   // A result held high across many cycles is counted once only.
   assign w_cap      = cReady & ~r_cready_q;

   // A pop needs a visible head. A capture into an empty FIFO therefore never
   // bypasses to the consumer in the same cycle.
   assign w_pop      = ~w_empty & m_ready;

   // A pop in the same cycle frees the slot, so a full FIFO can still take a
   // word. frame_start discards any coincident capture.
   assign w_wr       = w_cap & ~frame_start & (~w_full | w_pop);
   assign w_drop     = w_cap & ~frame_start & w_full & ~w_pop;

   assign w_col_last = (r_col == COL_LAST);
   assign w_row_last = (r_row == ROW_LAST);

`ifdef CONV_RELU_EN
   assign w_store    = finalsum[DATA_W-1] ? '0 : finalsum;
`else
   assign w_store    = finalsum;
`endif

   assign w_wr_entry = '{data: w_store,
                         last: w_col_last,
                         fend: w_col_last & w_row_last};

   assign w_head     = r_mem[r_rd_ptr[FIFO_AW-1:0]];

   // ---------------------------------------------------------------------------
   // Storage (no reset needed: a stale entry is never visible, because the
   // head is forced to 0 while the FIFO is empty)
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (w_wr)
         r_mem[r_wr_ptr[FIFO_AW-1:0]] <= w_wr_entry;
   end

   // ---------------------------------------------------------------------------
   // Pointers and capture edge detect
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clk or negedge RstIn) begin
      if (!RstIn) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_cready_q <= 1'b0;
      end else begin
         // The cReady edge detector keeps tracking during frame_start. A level
         // still high when frame_start occurs is not captured again later.
         r_cready_q <= cReady;
         if (frame_start) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_wr)
               r_wr_ptr <= r_wr_ptr + (FIFO_AW + 1)'(1);
            if (w_pop)
               r_rd_ptr <= r_rd_ptr + (FIFO_AW + 1)'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Position counters: these advance on every capture, including dropped ones,
   // so the tags stay aligned with the image after an overflow.
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clk or negedge RstIn) begin
      if (!RstIn) begin
         r_col <= '0;
         r_row <= '0;
      end else if (frame_start) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_cap) begin
         if (w_col_last) begin
            r_col <= '0;
            r_row <= w_row_last ? '0 : r_row + RW'(1);
         end else begin
            r_col <= r_col + CW'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Status flags
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clk or negedge RstIn) begin
      if (!RstIn) begin
         r_overflow   <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         // A new drop takes precedence over clear_err in the same cycle, so
         // that event is not lost. frame_start leaves overflow unchanged.
         if (w_drop)
            r_overflow <= 1'b1;
         else if (clear_err)
            r_overflow <= 1'b0;

         if (frame_start)
            r_frame_done <= 1'b0;
         else
            r_frame_done <= w_pop & w_head.fend;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs: all are derived from reset registers, so they go to 0 as soon as
   // reset is asserted.
   // ---------------------------------------------------------------------------
   assign m_valid     = ~w_empty;
   assign m_data      = w_empty ? '0 : w_head.data;
   assign m_last      = ~w_empty & w_head.last;
   assign m_frame_end = ~w_empty & w_head.fend;
   assign level       = w_level;
   assign overflow    = r_overflow;
   assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_conv_result_collector.sv
// -----------------------------------------------------------------------------
// tb_conv_result_collector
//
// Self-checking bench for conv_result_collector (DATA_W=16, IMG_W=8, IMG_H=8,
// FIFO_AW=4). A negedge scoreboard models the FIFO contents, the tags, the
// overflow flag and the frame_done pulse, and checks all outputs every cycle.
// A table of capture vectors and some hand-written sequences cover reset,
// streaming, held cReady, overflow, cap+pop on a full FIFO, and frame_start.
// Build with CONV_RELU_EN defined to check the clamping build.
// -----------------------------------------------------------------------------
module tb_conv_result_collector;

   localparam int DATA_W  = 16;
   localparam int IMG_W   = 8;
   localparam int IMG_H   = 8;
   localparam int FIFO_AW = 4;
   localparam int DEPTH   = 16;

   logic              Clk;
   logic              RstIn;
   logic              frame_start;
   logic [DATA_W-1:0] finalsum;
   logic              cReady;
   logic              clear_err;
   logic [DATA_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready;
   logic              m_last;
   logic              m_frame_end;
   logic [FIFO_AW:0]  level;
   logic              overflow;
   logic              frame_done;

   conv_result_collector #(
      .DATA_W (DATA_W),
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .FIFO_AW(FIFO_AW)
   ) dut (
      .Clk        (Clk),
      .RstIn      (RstIn),
      .frame_start(frame_start),
      .finalsum   (finalsum),
      .cReady     (cReady),
      .clear_err  (clear_err),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_last     (m_last),
      .m_frame_end(m_frame_end),
      .level      (level),
      .overflow   (overflow),
      .frame_done (frame_done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef CONV_RELU_EN
      return v[15] ? 16'h0000 : v;
`else
      return v;
`endif
   endfunction

   // ---------------------------------------------------------------------------
   // Scoreboard model, evaluated at negedge, where inputs and outputs are stable
   // ---------------------------------------------------------------------------
   typedef struct {
      logic [15:0] data;
      logic        last;
      logic        fend;
   } sb_t;

   sb_t q[$];
   int  m_col = 0, m_row = 0;
   bit  m_prev = 0, m_ovf = 0, m_fd = 0;
   int  n_pops = 0, n_last = 0, n_fd = 0;
   bit  s_pop, s_full, s_cap, s_drop, s_nfd;
   sb_t s_e;

   always @(negedge Clk) begin
      if (!RstIn) begin
         q.delete();
         m_col = 0; m_row = 0;
         m_prev = 0; m_ovf = 0; m_fd = 0;
      end else begin
         chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
         chk("level", 32'(level), 32'(q.size()));
         chk("overflow", 32'(overflow), 32'(m_ovf));
         chk("frame_done", 32'(frame_done), 32'(m_fd));
         if (frame_done) n_fd++;
         if (q.size() != 0) begin
            chk("m_data", 32'(m_data), 32'(q[0].data));
            chk("m_last", 32'(m_last), 32'(q[0].last));
            chk("m_frame_end", 32'(m_frame_end), 32'(q[0].fend));
         end else begin
            chk("empty_head", {13'd0, m_data, m_last, m_frame_end}, 32'd0);
         end

         // Predict the effect of the coming posedge.
         s_pop  = (q.size() != 0) && m_ready;
         s_full = (q.size() >= DEPTH);
         s_cap  = cReady && !m_prev;
         m_prev = cReady;
         s_drop = 0;
         s_nfd  = 0;
         if (frame_start) begin
            q.delete();
            m_col = 0; m_row = 0;
         end else begin
            if (s_pop) begin
               s_nfd = q[0].fend;
               n_pops++;
               if (q[0].last) n_last++;
               void'(q.pop_front());
            end
            if (s_cap) begin
               if (!s_full || s_pop) begin
                  s_e.data = relu(finalsum);
                  s_e.last = (m_col == IMG_W - 1);
                  s_e.fend = s_e.last && (m_row == IMG_H - 1);
                  q.push_back(s_e);
               end else begin
                  s_drop = 1;
               end
               if (m_col == IMG_W - 1) begin
                  m_col = 0;
                  m_row = (m_row == IMG_H - 1) ? 0 : m_row + 1;
               end else begin
                  m_col = m_col + 1;
               end
            end
         end
         if (s_drop) m_ovf = 1;
         else if (clear_err) m_ovf = 0;
         m_fd = s_nfd;
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers (drive at posedge+1)
   // ---------------------------------------------------------------------------
   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic pulse(input logic [15:0] d);
      finalsum = d;
      cReady   = 1'b1;
      cyc();
      cReady   = 1'b0;
      cyc();
   endtask

   task automatic restart();
      frame_start = 1'b1;
      clear_err   = 1'b1;
      cyc();
      frame_start = 1'b0;
      clear_err   = 1'b0;
   endtask

   typedef struct {
      logic [15:0] fsum;
      bit          hold;
      int          n;
      int          exp_lvl;
      bit          exp_ovf;
      logic [15:0] exp_head;
   } vec_t;

   vec_t vt [5];

   initial begin
      vt[0] = '{16'h0042, 1'b1, 10, 1,  1'b0, 16'h0042};
      vt[1] = '{16'hFFF0, 1'b0, 1,  1,  1'b0, relu(16'hFFF0)};
      vt[2] = '{16'h1234, 1'b0, 17, 16, 1'b1, 16'h1234};
      vt[3] = '{16'h8001, 1'b0, 3,  3,  1'b0, relu(16'h8001)};
      vt[4] = '{16'h7FFF, 1'b1, 4,  1,  1'b0, 16'h7FFF};

      RstIn = 1'b1; frame_start = 1'b0; finalsum = '0;
      cReady = 1'b0; clear_err = 1'b0; m_ready = 1'b0;
      #2 RstIn = 1'b0;
      #1;
      chk("reset_outputs", {13'd0, m_data, m_valid, m_last, m_frame_end},  32'd0);
      chk("reset_status", {26'd0, level, overflow, frame_done}, 32'd0);
      repeat (2) cyc();
      RstIn = 1'b1;
      cyc();

      // Asynchronous reset in the middle of a stream, with level 5
      restart();
      for (int i = 0; i < 5; i++) pulse(16'(i + 100));
      chk("pre_reset_level", 32'(level), 32'd5);
      #2 RstIn = 1'b0;
      #1;
      chk("async_reset_out", {13'd0, m_data, m_valid, m_last, m_frame_end}, 32'd0);
      chk("async_reset_status", {26'd0, level, overflow, frame_done}, 32'd0);
      cyc();
      RstIn = 1'b1;
      cyc();
      chk("post_reset_level", 32'(level), 32'd0);
      chk("post_reset_valid", 32'(m_valid), 32'd0);

      // Full 8x8 frame streamed with m_ready held high
      restart();
      m_ready = 1'b1;
      n_pops = 0; n_last = 0; n_fd = 0;
      for (int i = 0; i < 64; i++) pulse(16'(i));
      repeat (4) cyc();
      chk("stream_pops", 32'(n_pops), 32'd64);
      chk("stream_lasts", 32'(n_last), 32'd8);
      chk("stream_frame_done", 32'(n_fd), 32'd1);
      chk("stream_overflow", 32'(overflow), 32'd0);
      m_ready = 1'b0;

      // Table-driven capture vectors
      for (int v = 0; v < 5; v++) begin
         restart();
         if (vt[v].hold) begin
            finalsum = vt[v].fsum;
            cReady   = 1'b1;
            repeat (vt[v].n) cyc();
            cReady   = 1'b0;
            cyc();
         end else begin
            for (int k = 0; k < vt[v].n; k++) pulse(vt[v].fsum);
         end
         chk($sformatf("vec%0d_level", v), 32'(level), 32'(vt[v].exp_lvl));
         chk($sformatf("vec%0d_overflow", v), 32'(overflow), 32'(vt[v].exp_ovf));
         chk($sformatf("vec%0d_head", v), 32'(m_data), 32'(vt[v].exp_head));
      end

      // Overflow with 17 pulses into 16 slots, then clear_err and drain
      restart();
      for (int i = 0; i < 17; i++) pulse(16'(i));
      chk("ovf_level", 32'(level), 32'd16);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_col", 32'(dut.r_col), 32'd1);
      clear_err = 1'b1;
      cyc();
      clear_err = 1'b0;
      chk("ovf_cleared", 32'(overflow), 32'd0);
      m_ready = 1'b1;
      n_pops = 0;
      repeat (20) cyc();
      chk("drain_pops", 32'(n_pops), 32'd16);
      chk("drain_level", 32'(level), 32'd0);
      m_ready = 1'b0;

      // Full FIFO with cap and pop in the same cycle, then frame_start with cap
      restart();
      for (int i = 0; i < 16; i++) pulse(16'(i + 16'h200));
      chk("full_level", 32'(level), 32'd16);
      finalsum = 16'hABCD;
      cReady   = 1'b1;
      m_ready  = 1'b1;
      cyc();
      cReady   = 1'b0;
      m_ready  = 1'b0;
      cyc();
      chk("cap_pop_full_level", 32'(level), 32'd16);
      chk("cap_pop_full_ovf", 32'(overflow), 32'd0);
      frame_start = 1'b1;
      cReady      = 1'b1;
      finalsum    = 16'h5555;
      cyc();
      frame_start = 1'b0;
      cReady      = 1'b0;
      chk("fs_cap_level", 32'(level), 32'd0);
      chk("fs_cap_col", 32'(dut.r_col), 32'd0);
      cyc();
      chk("fs_cap_valid", 32'(m_valid), 32'd0);

      repeat (2) cyc();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
